// File: rtl/time_pkg.sv
// Shared encodings for the time controller: select codes, field limits, modes, write-engine states.
// Field indices double as bit positions in the dirty mask (seconds written first).
package time_pkg;

   typedef struct packed {
      logic [6:0] h;
      logic [6:0] m;
      logic [6:0] s;
   } hms_t;

   localparam logic [1:0] SEL_H = 2'b00;
   localparam logic [1:0] SEL_M = 2'b01;
   localparam logic [1:0] SEL_S = 2'b11;

   localparam logic [6:0] H_MAX  = 7'd23;
   localparam logic [6:0] MS_MAX = 7'd59;

   localparam logic [1:0] MODE_RUN   = 2'd0;
   localparam logic [1:0] MODE_SET_H = 2'd1;
   localparam logic [1:0] MODE_SET_M = 2'd2;
   localparam logic [1:0] MODE_SET_S = 2'd3;

   localparam logic [1:0] W_IDLE   = 2'd0;
   localparam logic [1:0] W_SETUP  = 2'd1;
   localparam logic [1:0] W_STROBE = 2'd2;

   localparam logic [1:0] F_S = 2'd0;
   localparam logic [1:0] F_M = 2'd1;
   localparam logic [1:0] F_H = 2'd2;

   function automatic logic [1:0] first_dirty(input logic [2:0] dirty);
      if (dirty[F_S])      return F_S;
      else if (dirty[F_M]) return F_M;
      else                 return F_H;
   endfunction

   function automatic logic [1:0] sel_code(input logic [1:0] f);
      case (f)
         F_S:     return SEL_S;
         F_M:     return SEL_M;
         default: return SEL_H;
      endcase
   endfunction

   function automatic logic [6:0] field_val(input hms_t t, input logic [1:0] f);
      case (f)
         F_S:     return t.s;
         F_M:     return t.m;
         default: return t.h;
      endcase
   endfunction

endpackage

// File: rtl/time_field_inc.sv
// Combinational wrap-incrementer for one time field: value+1, or 0 with carry once value reaches max.
// Out-of-range inputs also wrap to 0, so a field can never escape its limit.
module time_field_inc (
   input  logic [6:0] value,
   input  logic [6:0] max,
   output logic [6:0] next,
   output logic       carry
);

   assign carry = (value >= max);
   assign next  = carry ? 7'd0 : value + 7'd1;

endmodule

// File: rtl/time_ctrl.sv
// Time register controller: 1 Hz advance with carry, button set mode, and a two-cycle-per-field write engine.
// Shadow updates one cycle after an event; tick/inc arriving while busy wait in one-deep pending flags.
module time_ctrl
   import time_pkg::*;
#(
   parameter int H_INIT = 0,
   parameter int M_INIT = 0,
   parameter int S_INIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        btn_mode,
   input  logic        btn_inc,
   output logic        IE,
   output logic        enSet,
   output logic [1:0]  select,
   output logic [6:0]  D,
   output logic [20:0] t_shadow,
   output logic [1:0]  mode,
   output logic        busy
);

   hms_t       t, t_n, inc_v;
   logic [2:0] dirty, dirty_rem, set_mask;
   logic [1:0] wstate, cur, nf, mode_n;
   logic       pend_tick, pend_inc;
   logic       idle_free, do_tick, do_inc;
   logic       c_s, c_m, h_carry_unused;

   time_field_inc u_inc_s (.value(t.s), .max(MS_MAX), .next(inc_v.s), .carry(c_s));
   time_field_inc u_inc_m (.value(t.m), .max(MS_MAX), .next(inc_v.m), .carry(c_m));
   time_field_inc u_inc_h (.value(t.h), .max(H_MAX),  .next(inc_v.h), .carry(h_carry_unused));

   assign t_shadow = t;
   assign busy     = (wstate != W_IDLE) || (dirty != 3'b000);

   always_comb begin
      mode_n    = btn_mode ? mode + 2'd1 : mode;
      idle_free = (wstate == W_IDLE) && (dirty == 3'b000);
      // Mode change lands first, so tick/inc are judged against the new mode.
      do_tick   = idle_free && (tick_1hz || pend_tick) && (mode_n == MODE_RUN);
      do_inc    = idle_free && (btn_inc || pend_inc) && (mode_n != MODE_RUN);
      t_n       = t;
      set_mask  = 3'b000;
      if (do_tick) begin
         t_n.s         = inc_v.s;
         set_mask[F_S] = 1'b1;
         if (c_s) begin
            t_n.m         = inc_v.m;
            set_mask[F_M] = 1'b1;
            if (c_m) begin
               t_n.h         = inc_v.h;
               set_mask[F_H] = 1'b1;
            end
         end
      end else if (do_inc) begin
         case (mode_n)
            MODE_SET_H: begin t_n.h = inc_v.h; set_mask[F_H] = 1'b1; end
            MODE_SET_M: begin t_n.m = inc_v.m; set_mask[F_M] = 1'b1; end
            default:    begin t_n.s = inc_v.s; set_mask[F_S] = 1'b1; end
         endcase
      end
      dirty_rem = dirty;
      if (wstate == W_STROBE) dirty_rem = dirty & ~(3'b001 << cur);
      nf = first_dirty(dirty_rem);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t         <= {7'(H_INIT), 7'(M_INIT), 7'(S_INIT)};
         mode      <= MODE_RUN;
         wstate    <= W_IDLE;
         dirty     <= 3'b111;
         cur       <= F_S;
         pend_tick <= 1'b0;
         pend_inc  <= 1'b0;
         IE        <= 1'b0;
         enSet     <= 1'b0;
         select    <= SEL_H;
         D         <= 7'd0;
      end else begin
         t     <= t_n;
         mode  <= mode_n;
         // A field touched during its own write stays dirty and is rewritten.
         dirty <= dirty_rem | set_mask;

         if (idle_free)                               pend_tick <= 1'b0;
         else if (tick_1hz && (mode_n == MODE_RUN))   pend_tick <= 1'b1;
         if (idle_free)                               pend_inc  <= 1'b0;
         else if (btn_inc && (mode_n != MODE_RUN))    pend_inc  <= 1'b1;

         case (wstate)
            W_IDLE: begin
               if (dirty != 3'b000) begin
                  cur    <= nf;
                  select <= sel_code(nf);
                  D      <= field_val(t, nf);
                  enSet  <= 1'b1;
                  wstate <= W_SETUP;
               end
            end
            W_SETUP: begin
               IE     <= 1'b1;
               wstate <= W_STROBE;
            end
            W_STROBE: begin
               IE <= 1'b0;
               if (dirty_rem != 3'b000) begin
                  cur    <= nf;
                  select <= sel_code(nf);
                  D      <= field_val(t, nf);
                  wstate <= W_SETUP;
               end else begin
                  enSet  <= 1'b0;
                  wstate <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_time_ctrl.sv
// Bench for time_ctrl: vector table, directed multi-cycle sequences, and randomized events vs a wall-clock model.
module tb_time_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1hz = 1'b0;
   logic        btn_mode = 1'b0;
   logic        btn_inc = 1'b0;
   logic        IE, enSet, busy;
   logic [1:0]  select, mode;
   logic [6:0]  D;
   logic [20:0] t_shadow;

   always #5 clk = ~clk;

   time_ctrl dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .IE(IE), .enSet(enSet), .select(select), .D(D), .t_shadow(t_shadow), .mode(mode), .busy(busy)
   );

   int vec = 0;
   int miss = 0;

   // Model state: wall-clock time and front-panel mode.
   int mh = 0, mm = 0, ms = 0, mmode = 0;
   logic [8:0] exp_q[$];

   // Observed register writes and the register image they build.
   logic [8:0] wq[$];
   int img_h = -1, img_m = -1, img_s = -1;
   int en_cnt = 0;
   logic ie_q = 1'b0;

   always @(negedge clk) begin
      if (IE && !ie_q) begin
         wq.push_back({select, D});
         case (select)
            2'b00: img_h = int'(D);
            2'b01: img_m = int'(D);
            2'b11: img_s = int'(D);
            default: begin
               vec++; miss++;
               $display("FAIL select_code: got %b, required one of 00/01/11", select);
            end
         endcase
      end
      if (enSet) en_cnt++;
      ie_q = IE;
   end

   typedef struct {
      bit t, bm, bi;
      int h, m, s, md;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit t, input bit bm, input bit bi);
      tick_1hz = t; btn_mode = bm; btn_inc = bi;
      cyc();
      tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
   endtask

   task automatic wait_idle();
      int quiet = 0;
      int n = 0;
      while (quiet < 3 && n < 200) begin
         cyc();
         n++;
         quiet = busy ? 0 : quiet + 1;
      end
      if (quiet < 3) begin
         vec++; miss++;
         $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, n);
      end
   endtask

   function automatic int hms(input int h, input int m, input int s);
      return (h << 14) | (m << 7) | s;
   endfunction

   task automatic model_event(input bit t, input bit bm, input bit bi);
      int oh = mh, om = mm, os = ms, tot;
      exp_q.delete();
      if (bm) mmode = (mmode + 1) % 4;
      if (mmode == 0 && t) begin
         tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
         mh = tot / 3600; mm = (tot / 60) % 60; ms = tot % 60;
      end else if (mmode != 0 && bi) begin
         case (mmode)
            1: mh = (mh + 1) % 24;
            2: mm = (mm + 1) % 60;
            default: ms = (ms + 1) % 60;
         endcase
      end
      if (ms != os) exp_q.push_back({2'b11, 7'(ms)});
      if (mm != om) exp_q.push_back({2'b01, 7'(mm)});
      if (mh != oh) exp_q.push_back({2'b00, 7'(mh)});
   endtask

   task automatic press(input bit t, input bit bm, input bit bi);
      model_event(t, bm, bi);
      pulse(t, bm, bi);
      wait_idle();
   endtask

   task automatic chk_writes(input string nm);
      chk({nm, " write_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
         chk($sformatf("%s write%0d {sel,D}", nm, i), int'(wq[i]), int'(exp_q[i]));
   endtask

   task automatic do_event(input bit t, input bit bm, input bit bi, input string nm);
      wq.delete();
      press(t, bm, bi);
      chk({nm, " shadow"}, int'(t_shadow), hms(mh, mm, ms));
      chk({nm, " mode"}, int'(mode), mmode);
      chk_writes(nm);
   endtask

   task automatic to_run();
      for (int i = 0; i < 4 && mmode != 0; i++) press(0, 1, 0);
   endtask

   task automatic set_time(input int th, input int tm, input int ts);
      to_run();
      press(0, 1, 0);
      repeat ((th - mh + 24) % 24) press(0, 0, 1);
      press(0, 1, 0);
      repeat ((tm - mm + 60) % 60) press(0, 0, 1);
      press(0, 1, 0);
      repeat ((ts - ms + 60) % 60) press(0, 0, 1);
      press(0, 1, 0);
      chk($sformatf("set_time %0d:%0d:%0d", th, tm, ts), int'(t_shadow), hms(th, tm, ts));
   endtask

   // Starts in the cycle right after a reset edge; checks the 3-field init sync.
   task automatic check_sync(input string nm);
      logic [1:0] sels[3];
      sels[0] = 2'b11; sels[1] = 2'b01; sels[2] = 2'b00;
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         cyc();
         chk($sformatf("%s c%0d IE", nm, k), int'(IE), (k % 2 == 0) ? 1 : 0);
         chk($sformatf("%s c%0d enSet", nm, k), int'(enSet), 1);
         if (k % 2 == 0) begin
            chk($sformatf("%s c%0d select", nm, k), int'(select), int'(sels[k/2-1]));
            chk($sformatf("%s c%0d D", nm, k), int'(D), 0);
         end
      end
      cyc();
      chk({nm, " busy after sync"}, int'(busy), 0);
      chk({nm, " enSet after sync"}, int'(enSet), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(); cyc();
      mh = 0; mm = 0; ms = 0; mmode = 0;
      chk("reset shadow", int'(t_shadow), 0);
      chk("reset mode", int'(mode), 0);
      chk("reset IE", int'(IE), 0);
      chk("reset enSet", int'(enSet), 0);
      chk("reset select", int'(select), 0);
      chk("reset D", int'(D), 0);
      chk("reset busy", int'(busy), 1);
      check_sync("init");
   endtask

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1, 0, 0, 0, 0, 1, 0};
      tbl[1] = '{0, 1, 1, 1, 0, 1, 1};
      tbl[2] = '{1, 0, 0, 1, 0, 1, 1};
      tbl[3] = '{0, 1, 0, 1, 0, 1, 2};
      tbl[4] = '{0, 0, 1, 1, 1, 1, 2};
      tbl[5] = '{1, 1, 0, 1, 1, 1, 3};
      tbl[6] = '{0, 0, 1, 1, 1, 2, 3};
      tbl[7] = '{0, 1, 1, 1, 1, 2, 0};
      tbl[8] = '{1, 0, 1, 1, 1, 3, 0};
      tbl[9] = '{1, 1, 0, 1, 1, 3, 1};

      do_reset();

      for (int i = 0; i < 10; i++) begin
         wq.delete();
         press(tbl[i].t, tbl[i].bm, tbl[i].bi);
         chk($sformatf("vec%0d shadow", i), int'(t_shadow), hms(tbl[i].h, tbl[i].m, tbl[i].s));
         chk($sformatf("vec%0d mode", i), int'(mode), tbl[i].md);
         chk_writes($sformatf("vec%0d", i));
      end

      // Seconds-only write, then a carry into minutes.
      set_time(0, 0, 58);
      do_event(1, 0, 0, "tick58");
      repeat (10) cyc();
      do_event(1, 0, 0, "tick59");

      // Full-day wrap: three fields, six write cycles.
      set_time(23, 59, 59);
      en_cnt = 0;
      do_event(1, 0, 0, "daywrap");
      chk("daywrap write cycles", en_cnt, 6);

      // Hours set mode: no carry into minutes, tick ignored.
      set_time(22, 0, 0);
      do_event(0, 1, 0, "seth enter");
      repeat (3) do_event(0, 0, 1, "seth inc");
      do_event(1, 0, 0, "seth tick");
      to_run();

      // Two ticks during the init sync: one applied afterwards, the other dropped.
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      mh = 0; mm = 0; ms = 0; mmode = 0;
      wq.delete();
      cyc(); cyc();
      chk("pend strobe c2 IE", int'(IE), 1);
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
      cyc();
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
      wait_idle();
      ms = 1;
      chk("pend shadow", int'(t_shadow), hms(0, 0, 1));
      chk("pend write_count", wq.size(), 4);
      if (wq.size() == 4) chk("pend last write", int'(wq[3]), int'({2'b11, 7'd1}));

      // Reset in the strobe cycle of a minutes write.
      set_time(0, 0, 59);
      model_event(1, 0, 0);
      pulse(1, 0, 0);
      repeat (4) cyc();
      chk("rstmid strobe IE", int'(IE), 1);
      chk("rstmid strobe select", int'(select), 1);
      rst = 1'b1;
      cyc();
      mh = 0; mm = 0; ms = 0; mmode = 0;
      chk("rstmid IE", int'(IE), 0);
      chk("rstmid shadow", int'(t_shadow), 0);
      chk("rstmid busy", int'(busy), 1);
      check_sync("rstmid");

      // Random isolated events against the wall-clock model.
      set_time(23, 59, 50);
      for (int i = 0; i < 150; i++) begin
         bit t, bm, bi;
         t  = ($urandom_range(0, 1) == 1);
         bm = ($urandom_range(0, 3) == 0);
         bi = ($urandom_range(0, 1) == 1);
         do_event(t, bm, bi, $sformatf("rand%0d", i));
      end
      chk("image h", img_h, mh);
      chk("image m", img_m, mm);
      chk("image s", img_s, ms);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
